rc4_prga_decrypt: RTL

- Second half of the RC4 decryption datapath, and the reader of the S-memory that the key-scheduling swap machine fills.
- After key scheduling finishes, this block runs the RC4 pseudo-random generation algorithm (PRGA) over S. It swaps S entries in place and XORs each keystream byte with the matching byte of the encrypted-message ROM.
- Each result is written to the decrypted-message RAM.
- An optional plaintext check (lowercase ASCII or space only) lets the top level abort bad keys early during key search.

---
 rtl/rc4_prga_decrypt_if.sv | 50 +++++
 rtl/rc4_prga_decrypt.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_decrypt_if.sv
// ---------------------------------------------------------------------------
// rc4_prga_decrypt_if
// Groups the memory and handshake signals of the RC4 PRGA/decrypt block.
//
// Signals:
//   start     level request to begin decryption (sampled only when idle)
//   s_q       S-memory read data (1-cycle synchronous read)
//   s_addr    S-memory address
//   s_data    S-memory write data
//   s_wren    S-memory write enable
//   msg_q     encrypted-message ROM read data (1-cycle synchronous read)
//   msg_addr  encrypted-message ROM address
//   dec_addr  decrypted-message RAM address
//   dec_data  decrypted-message RAM write data
//   dec_wren  decrypted-message RAM write enable
//   done      sticky completion flag
//   valid     meaningful when done=1; 1 = every written byte passed the check
//
// Modports:
//   slave   the decrypt engine side
//   master  the surrounding system (memories and controller) side
// ---------------------------------------------------------------------------
interface rc4_prga_decrypt_if #(
    parameter int MSG_AW = 5
);
    logic              start;
    logic [7:0]        s_q;
    logic [7:0]        s_addr;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [7:0]        msg_q;
    logic [MSG_AW-1:0] msg_addr;
    logic [MSG_AW-1:0] dec_addr;
    logic [7:0]        dec_data;
    logic              dec_wren;
    logic              done;
    logic              valid;

    modport slave (
        input  start, s_q, msg_q,
        output s_addr, s_data, s_wren, msg_addr,
               dec_addr, dec_data, dec_wren, done, valid
    );

    modport master (
        output start, s_q, msg_q,
        input  s_addr, s_data, s_wren, msg_addr,
               dec_addr, dec_data, dec_wren, done, valid
    );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// ---------------------------------------------------------------------------
// rc4_prga_decrypt
// RC4 pseudo-random generation over a pre-scheduled S-memory. For each
// message byte k it advances i, accumulates j, swaps S[i]/S[j] in place,
// fetches S[S[i]+S[j]] and XORs it with encrypted byte k, writing the result
// into the decrypted-message RAM. With CHECK_ASCII=1 the run stops after the
// first decrypted byte that is not lowercase ASCII or space, so a key search
// can reject a wrong key early.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset
//   bus    rc4_prga_decrypt_if.slave: start, S-memory port, message ROM
//          port, decrypted RAM port, done/valid status
//
// Parameters:
//   MSG_LEN      number of message bytes processed (1..256)
//   MSG_AW       message ROM / decrypted RAM address width
//   CHECK_ASCII  1 = abort on first non-text decrypted byte
//
// All outputs are decoded from the state and working registers; after reset
// the engine sits in IDLE with k=0, so every output reads 0.
// ---------------------------------------------------------------------------
module rc4_prga_decrypt #(
    parameter int MSG_LEN     = 32,
    parameter int MSG_AW      = 5,
    parameter bit CHECK_ASCII = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    rc4_prga_decrypt_if.slave     bus
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INC_I,
        ST_WAIT_SI,
        ST_READ_SI,
        ST_ADDR_SJ,
        ST_WAIT_SJ,
        ST_READ_SJ,
        ST_WR_I,
        ST_WR_J,
        ST_ADDR_F,
        ST_WAIT_F,
        ST_READ_F,
        ST_WR_DEC,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    state_t            state_q, state_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [7:0]        si_q, si_d;
    logic [7:0]        sj_q, sj_d;
    logic [7:0]        f_q, f_d;
    logic [MSG_AW-1:0] k_q, k_d;
    // Cleared by the first failing byte; reported as valid once done.
    logic              ok_q, ok_d;

    // Lowercase letters and space are the only accepted plaintext bytes.
    function automatic logic is_text(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            i_q     <= 8'h00;
            j_q     <= 8'h00;
            si_q    <= 8'h00;
            sj_q    <= 8'h00;
            f_q     <= 8'h00;
            k_q     <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            k_q     <= k_d;
            ok_q    <= ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        k_d     = k_q;
        ok_d    = ok_q;

        bus.s_addr   = 8'h00;
        bus.s_data   = 8'h00;
        bus.s_wren   = 1'b0;
        bus.msg_addr = k_q;
        bus.dec_addr = '0;
        bus.dec_data = 8'h00;
        bus.dec_wren = 1'b0;
        bus.done     = 1'b0;
        bus.valid    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ok_d    = 1'b1;
                    state_d = ST_INC_I;
                end
            end
            // Present the incremented index immediately so the read of
            // S[i] overlaps the register update.
            ST_INC_I: begin
                i_d         = i_q + 8'd1;
                bus.s_addr  = i_q + 8'd1;
                state_d     = ST_WAIT_SI;
            end
            ST_WAIT_SI: begin
                bus.s_addr = i_q;
                state_d    = ST_READ_SI;
            end
            ST_READ_SI: begin
                bus.s_addr = i_q;
                si_d       = bus.s_q;
                j_d        = j_q + bus.s_q;
                state_d    = ST_ADDR_SJ;
            end
            ST_ADDR_SJ: begin
                bus.s_addr = j_q;
                state_d    = ST_WAIT_SJ;
            end
            ST_WAIT_SJ: begin
                bus.s_addr = j_q;
                state_d    = ST_READ_SJ;
            end
            ST_READ_SJ: begin
                bus.s_addr = j_q;
                sj_d       = bus.s_q;
                state_d    = ST_WR_I;
            end
            ST_WR_I: begin
                bus.s_addr = i_q;
                bus.s_data = sj_q;
                bus.s_wren = 1'b1;
                state_d    = ST_WR_J;
            end
            // Written second so that when i==j the stored value is si.
            ST_WR_J: begin
                bus.s_addr = j_q;
                bus.s_data = si_q;
                bus.s_wren = 1'b1;
                state_d    = ST_ADDR_F;
            end
            ST_ADDR_F: begin
                bus.s_addr = si_q + sj_q;
                state_d    = ST_WAIT_F;
            end
            ST_WAIT_F: begin
                bus.s_addr = si_q + sj_q;
                state_d    = ST_READ_F;
            end
            ST_READ_F: begin
                bus.s_addr = si_q + sj_q;
                f_d        = bus.s_q ^ bus.msg_q;
                state_d    = ST_WR_DEC;
            end
            // The failing byte is still written; the abort takes effect in NEXT.
            ST_WR_DEC: begin
                bus.dec_addr = k_q;
                bus.dec_data = f_q;
                bus.dec_wren = 1'b1;
                if (CHECK_ASCII && !is_text(f_q)) begin
                    ok_d = 1'b0;
                end
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (!ok_q || (k_q == K_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = ST_INC_I;
                end
            end
            ST_DONE: begin
                bus.done  = 1'b1;
                bus.valid = ok_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
